// File: rtl/vec_pkg.sv
// Shared types for the vector register-file sequencer: op encodings, FSM states and the
// buffered instruction record.
package vec_pkg;

  localparam int VEC_DATA_W = 512;
  localparam int VEC_ADDR_W = 2;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } seq_state_t;

  typedef struct packed {
    logic [1:0]            op;
    logic [VEC_ADDR_W-1:0] raddr;
    logic [VEC_ADDR_W-1:0] waddr;
    logic [VEC_DATA_W-1:0] wdata;
  } instr_t;

  function automatic logic op_is_alu(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/vec_instr_fifo.sv
// Synchronous instruction FIFO, head visible combinationally; push ignored when full, pop
// ignored when empty. DEPTH must be a power of two.
module vec_instr_fifo
  import vec_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  instr_t         push_dat,
  input  logic           pop,
  output instr_t         head_dat,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  instr_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == (PTR_W+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign head_dat = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/vec_rf_sequencer.sv
// In-order sequencer driving register_file: one-cycle issue, waits READ_LAT/ALU_LAT, read results
// held on rsp until accepted (stalls FSM only). Define VEC_SEQ_PERF_EN to add perf counters.
module vec_rf_sequencer
  import vec_pkg::*;
#(
  parameter int DATA_W     = VEC_DATA_W,
  parameter int ADDR_W     = VEC_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 1,
  parameter int ALU_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_raddr,
  input  logic [ADDR_W-1:0] instr_waddr,
  input  logic [DATA_W-1:0] instr_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rf_op_code,
  output logic [ADDR_W-1:0] rf_read_addr,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
`ifdef VEC_SEQ_PERF_EN
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_full,
`endif
  output logic              busy
);

  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_LAT    = (READ_LAT > ALU_LAT) ? READ_LAT : ALU_LAT;
  localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  seq_state_t          r_state;
  logic [1:0]          r_cur_op;
  logic [CNT_W-1:0]    r_cnt;

  instr_t              w_in;
  instr_t              w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FIFO_PTR_W:0] w_fifo_count;

  always_comb begin
    w_in       = '0;
    w_in.op    = instr_op;
    w_in.raddr = instr_raddr;
    w_in.waddr = instr_waddr;
    w_in.wdata = instr_wdata;
  end

  assign instr_ready = rst && !w_full;
  assign w_push      = instr_valid && instr_ready;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign busy        = (w_fifo_count != '0) || (r_state != S_IDLE);

  vec_instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_dat (w_in),
    .pop      (w_pop),
    .head_dat (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_fifo_count)
  );

  // rf_* are registered so they are valid for exactly the ISSUE cycle; otherwise a side-effect-free read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cur_op      <= OP_READ;
      r_cnt         <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rf_op_code    <= OP_READ;
      rf_read_addr  <= '0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cur_op   <= w_head.op;
            rf_op_code <= w_head.op;
            r_state    <= S_ISSUE;
            if (w_head.op == OP_WRITE) begin
              rf_write_addr <= w_head.waddr;
              rf_write_data <= w_head.wdata;
            end else if (w_head.op == OP_READ) begin
              rf_read_addr <= w_head.raddr;
            end
          end
        end
        S_ISSUE: begin
          rf_op_code    <= OP_READ;
          rf_write_data <= '0;
          if (r_cur_op == OP_WRITE) begin
            r_state <= S_IDLE;
          end else if (r_cur_op == OP_READ) begin
            r_cnt   <= CNT_W'(READ_LAT - 1);
            r_state <= S_WAIT;
          end else begin
            r_cnt   <= CNT_W'(ALU_LAT - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_cur_op == OP_READ) begin
              rsp_data  <= rf_read_data;
              rsp_valid <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VEC_SEQ_PERF_EN
  logic w_retire;

  assign w_retire = ((r_state == S_ISSUE) && (r_cur_op == OP_WRITE)) ||
                    ((r_state == S_WAIT) && (r_cnt == '0) && op_is_alu(r_cur_op)) ||
                    ((r_state == S_RESP) && rsp_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
      perf_full    <= '0;
    end else begin
      if (w_retire)                         perf_retired <= perf_retired + 32'd1;
      if ((r_state == S_RESP) && !rsp_ready) perf_stall   <= perf_stall + 32'd1;
      if (instr_valid && w_full)             perf_full    <= perf_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_rf_sequencer.sv
// Directed bench for vec_rf_sequencer with a behavioural register_file (1-cycle read, 1-cycle ALU).
module tb_vec_rf_sequencer;

  localparam int DW = 512;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_raddr;
  logic [AW-1:0] instr_waddr;
  logic [DW-1:0] instr_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rf_op_code;
  logic [AW-1:0] rf_read_addr;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_read_data;
  logic          busy;
`ifdef VEC_SEQ_PERF_EN
  logic [31:0]   perf_retired;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_full;
`endif

  int checks = 0;
  int errors = 0;

  vec_rf_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_raddr   (instr_raddr),
    .instr_waddr   (instr_waddr),
    .instr_wdata   (instr_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rf_op_code    (rf_op_code),
    .rf_read_addr  (rf_read_addr),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_read_data  (rf_read_data),
`ifdef VEC_SEQ_PERF_EN
    .perf_retired  (perf_retired),
    .perf_stall    (perf_stall),
    .perf_full     (perf_full),
`endif
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: A2 is the ALU destination, reads land one cycle after issue.
  logic [DW-1:0] rf_regs [4];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) rf_regs[i] <= '0;
      rf_read_data <= '0;
    end else begin
      case (rf_op_code)
        2'b00: rf_regs[rf_write_addr] <= rf_write_data;
        2'b01: rf_read_data <= rf_regs[rf_read_addr];
        2'b10: rf_regs[2] <= rf_regs[0] + rf_regs[1];
        default: rf_regs[2] <= rf_regs[0] * rf_regs[1];
      endcase
    end
  end

  task automatic push(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    int t;
    t = 0;
    while (instr_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout instr_ready=%b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_raddr = ra;
    instr_waddr = wa;
    instr_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr_valid = 1'b1;
    instr_op = 2'b00;
    instr_raddr = '0;
    instr_waddr = 2'd1;
    instr_wdata = 512'd99;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready cycle %0d got %b required 0", k, instr_ready);
      end
      checks++;
      if (rf_op_code !== 2'b01) begin
        errors++;
        $display("FAIL reset_opcode cycle %0d got %b required 01", k, rf_op_code);
      end
    end
    rst = 1'b1;
    instr_valid = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b required 1", instr_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL release_busy got %b required 0", busy);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL release_rsp valid=%b data=%0d required 0/0", rsp_valid, rsp_data);
    end
    checks++;
    if (rf_write_addr !== 2'd0 || rf_read_addr !== 2'd0 || rf_write_data !== '0) begin
      errors++;
      $display("FAIL release_rf wa=%0d ra=%0d wd=%0d required 0", rf_write_addr, rf_read_addr, rf_write_data);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int n00, first;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    logic [DW-1:0] d;
    n00 = 0; first = -1; wa = '0; wd = '0;
    push(2'b00, 2'd0, 2'd2, 512'd123456);
    for (int k = 0; k < 6; k++) begin
      if (rf_op_code === 2'b00) begin
        n00++;
        if (first < 0) begin
          first = k; wa = rf_write_addr; wd = rf_write_data;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n00 != 1 || first != 1) begin
      errors++;
      $display("FAIL write_pulse count=%0d at=%0d required 1 at 1", n00, first);
    end
    checks++;
    if (wa !== 2'd2 || wd !== 512'd123456) begin
      errors++;
      $display("FAIL write_fields addr=%0d data=%0d required 2/123456", wa, wd);
    end
    checks++;
    if (rf_write_data !== '0 || rf_op_code !== 2'b01) begin
      errors++;
      $display("FAIL idle_drive wd=%0d op=%b required 0/01", rf_write_data, rf_op_code);
    end

    first = -1; d = '0; ra = '0;
    push(2'b01, 2'd2, 2'd0, '0);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) ra = rf_read_addr;
      if (rsp_valid === 1'b1 && first < 0) begin
        first = k; d = rsp_data;
      end
      @(negedge clk);
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL read_latency got %0d required 3", first);
    end
    checks++;
    if (d !== 512'd123456 || ra !== 2'd2) begin
      errors++;
      $display("FAIL read_data got %0d addr %0d required 123456 addr 2", d, ra);
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_arith();
    bit ok;
    push(2'b00, 2'd0, 2'd0, 512'd12);
    push(2'b00, 2'd0, 2'd1, 512'd11);
    push(2'b10, 2'd0, 2'd0, '0);
    push(2'b01, 2'd2, 2'd0, '0);
    wait_rsp(60, ok);
    checks++;
    if (!ok || rsp_data !== 512'd23) begin
      errors++;
      $display("FAIL add_result seen=%0d got %0d required 23", ok, rsp_data);
    end
    @(negedge clk);
    push(2'b11, 2'd0, 2'd0, '0);
    push(2'b01, 2'd2, 2'd0, '0);
    wait_rsp(60, ok);
    checks++;
    if (!ok || rsp_data !== 512'd132) begin
      errors++;
      $display("FAIL mul_result seen=%0d got %0d required 132", ok, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    bit ok;
    int n;
    logic [DW-1:0] got [5];
    logic [DW-1:0] exp_v [5];
    exp_v[0] = 512'd12; exp_v[1] = 512'd11; exp_v[2] = 512'd132; exp_v[3] = 512'd77; exp_v[4] = 512'd12;
    push(2'b00, 2'd0, 2'd3, 512'd77);
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    push(2'b01, 2'd0, 2'd0, '0);
    wait_rsp(20, ok);
    checks++;
    if (!ok || rsp_data !== 512'd12) begin
      errors++;
      $display("FAIL bp_first seen=%0d got %0d required 12", ok, rsp_data);
    end
    push(2'b01, 2'd1, 2'd0, '0);
    push(2'b01, 2'd2, 2'd0, '0);
    push(2'b01, 2'd3, 2'd0, '0);
    push(2'b01, 2'd0, 2'd0, '0);
    checks++;
    if (instr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_full ready=%b busy=%b required 0/1", instr_ready, busy);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 512'd12) begin
      errors++;
      $display("FAIL bp_hold valid=%b data=%0d required 1/12", rsp_valid, rsp_data);
    end
`ifdef VEC_SEQ_PERF_EN
    begin
      logic [31:0] f0;
      f0 = perf_full;
      instr_valid = 1'b1;
      instr_op = 2'b01;
      repeat (2) @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (perf_full - f0 !== 32'd2) begin
        errors++;
        $display("FAIL perf_full delta %0d required 2", perf_full - f0);
      end
    end
`endif
    rsp_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      if (rsp_valid === 1'b1) begin
        got[n] = rsp_data;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL bp_drain_count got %0d required 5", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL bp_drain[%0d] got %0d required %0d", i, got[i], exp_v[i]);
      end
    end
  endtask

`ifdef VEC_SEQ_PERF_EN
  task automatic test_perf();
    bit ok;
    logic [31:0] r0, s0;
    repeat (3) @(negedge clk);
    r0 = perf_retired;
    s0 = perf_stall;
    rsp_ready = 1'b0;
    push(2'b00, 2'd0, 2'd0, 512'd3);
    push(2'b00, 2'd0, 2'd1, 512'd5);
    push(2'b10, 2'd0, 2'd0, '0);
    push(2'b11, 2'd0, 2'd0, '0);
    push(2'b01, 2'd2, 2'd0, '0);
    wait_rsp(60, ok);
    checks++;
    if (!ok || rsp_data !== 512'd15) begin
      errors++;
      $display("FAIL perf_seq_data seen=%0d got %0d required 15", ok, rsp_data);
    end
    repeat (4) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (perf_retired - r0 !== 32'd5) begin
      errors++;
      $display("FAIL perf_retired delta %0d required 5", perf_retired - r0);
    end
    checks++;
    if (perf_stall - s0 !== 32'd4) begin
      errors++;
      $display("FAIL perf_stall delta %0d required 4", perf_stall - s0);
    end
  endtask
`endif

  task automatic test_reset_mid_op();
    int bad;
    push(2'b10, 2'd0, 2'd0, '0);
    push(2'b00, 2'd0, 2'd3, 512'd5);
    checks++;
    if (rf_op_code !== 2'b10) begin
      errors++;
      $display("FAIL mid_issue_add got %b required 10", rf_op_code);
    end
    push(2'b01, 2'd3, 2'd0, '0);
    checks++;
    if (busy !== 1'b1 || rf_op_code !== 2'b01) begin
      errors++;
      $display("FAIL mid_wait busy=%b op=%b required 1/01", busy, rf_op_code);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rf_op_code !== 2'b01 || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b valid=%b op=%b ready=%b required 0/0/01/0",
               busy, rsp_valid, rf_op_code, instr_ready);
    end
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rf_op_code !== 2'b01 || rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_quiet activity cycles %0d required 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_arith();
    test_back_pressure();
`ifdef VEC_SEQ_PERF_EN
    test_perf();
`endif
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
